// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared count type and default VGA timing constants
package vga_pkg;

    typedef logic [10:0] cnt_t;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int H_FP_DEF     = 24;
    localparam int H_SYNC_DEF   = 136;
    localparam int H_BP_DEF     = 160;
    localparam int V_ACTIVE_DEF = 768;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 6;
    localparam int V_BP_DEF     = 29;

    // Largest total an 11-bit counter can sequence through
    localparam int CNT_LIMIT    = 2048;

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - video timing bundle between the generator and draw stages
interface vga_if;
    import vga_pkg::*;

    cnt_t        hcount;
    cnt_t        vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/timing_counter.sv
// rtl/timing_counter.sv - one timing axis: wrapping counter with blank/sync flags
module timing_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = 1344,
    parameter int ACTIVE     = 1024,
    parameter int SYNC_START = 1048,
    parameter int SYNC_END   = 1184
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output cnt_t count,
    output logic blnk,
    output logic sync,
    output logic wrap
);

    localparam cnt_t C_LAST       = cnt_t'(TOTAL - 1);
    localparam cnt_t C_ACTIVE     = cnt_t'(ACTIVE);
    localparam cnt_t C_SYNC_START = cnt_t'(SYNC_START);
    localparam cnt_t C_SYNC_END   = cnt_t'(SYNC_END);

    cnt_t w_nxt;

    // Next count; wrap tells the caller this edge returns the axis to zero
    always_comb begin
        w_nxt = count;
        wrap  = 1'b0;
        if (en) begin
            if (count == C_LAST) begin
                w_nxt = '0;
                wrap  = 1'b1;
            end else begin
                w_nxt = count + cnt_t'(1);
            end
        end
    end

    // Flags are decoded from the next count so they land with it, zero skew
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            blnk  <= 1'b0;
            sync  <= 1'b0;
        end else begin
            count <= w_nxt;
            blnk  <= (w_nxt >= C_ACTIVE);
            sync  <= (w_nxt >= C_SYNC_START) && (w_nxt < C_SYNC_END);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing generator; define VGA_FRAME_CNT_EN to add the frame_cnt output
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.out          vout,
    output logic        sof,
    output logic        eol
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int   H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // eol is registered, so it is armed while hcount sits one before the last pixel
    localparam cnt_t C_EOL_PRE = cnt_t'(H_TOTAL - 2);

    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_bad_cfg
        $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 11-bit counter range");
    end

    cnt_t w_h_count;
    cnt_t w_v_count;
    logic w_h_blnk;
    logic w_h_sync;
    logic w_h_wrap;
    logic w_v_blnk;
    logic w_v_sync;
    logic w_v_wrap;
    logic w_sof_nxt;
    logic w_eol_nxt;
    logic r_sof;
    logic r_eol;

    timing_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (w_h_count),
        .blnk  (w_h_blnk),
        .sync  (w_h_sync),
        .wrap  (w_h_wrap)
    );

    timing_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_h_wrap),
        .count (w_v_count),
        .blnk  (w_v_blnk),
        .sync  (w_v_sync),
        .wrap  (w_v_wrap)
    );

    // Both axes wrapping on the same edge means the next position is (0,0)
    assign w_sof_nxt = w_h_wrap & w_v_wrap;
    assign w_eol_nxt = (w_h_count == C_EOL_PRE);

    // Frame and line pulses registered alongside the counters they mark
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sof <= 1'b0;
            r_eol <= 1'b0;
        end else begin
            r_sof <= w_sof_nxt;
            r_eol <= w_eol_nxt;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Frames started since reset, updated on the same edge that raises sof
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
        end else if (w_sof_nxt) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign vout.hcount = w_h_count;
    assign vout.vcount = w_v_count;
    assign vout.hsync  = w_h_sync;
    assign vout.vsync  = w_v_sync;
    assign vout.hblnk  = w_h_blnk;
    assign vout.vblnk  = w_v_blnk;
    // Draw stages replace the pixel value downstream
    assign vout.rgb    = 12'h000;
    assign sof         = r_sof;
    assign eol         = r_eol;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int DH_A = 1024, DH_F = 24, DH_S = 136, DH_B = 160;
    localparam int DV_A = 768,  DV_F = 3,  DV_S = 6,   DV_B = 29;
    localparam int DHT  = DH_A + DH_F + DH_S + DH_B;

    localparam int SH_A = 16, SH_F = 2, SH_S = 3, SH_B = 4;
    localparam int SV_A = 10, SV_F = 1, SV_S = 2, SV_B = 3;
    localparam int SHT  = SH_A + SH_F + SH_S + SH_B;
    localparam int SVT  = SV_A + SV_F + SV_S + SV_B;
    localparam int S_FRAME = SHT * SVT;

    logic clk;
    logic rst;
    logic sof_def, eol_def, sof_sml, eol_sml;

    vga_if u_if_def ();
    vga_if u_if_sml ();

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_def_o, fc_sml_o;
`endif

    vga_timing_gen u_def (
        .clk   (clk),
        .rst   (rst),
        .vout  (u_if_def),
        .sof   (sof_def),
        .eol   (eol_def)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt (fc_def_o)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
        .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B)
    ) u_sml (
        .clk   (clk),
        .rst   (rst),
        .vout  (u_if_sml),
        .sof   (sof_sml),
        .eol   (eol_sml)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt (fc_sml_o)
`endif
    );

    int          n_total = 0;
    int          n_bad   = 0;
    int          k       = 0;
    int          cyc     = 0;
    int          prev_cyc = 0;
    int          eol_cnt = 0;
    bit          have_prev = 0;
    logic [15:0] fc_def  = '0;
    logic [15:0] fc_sml  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Position after k clock edges since release, laid out as the observed vector
    function automatic logic [39:0] model(input int kk, input int ha, input int hf, input int hs,
                                          input int hb, input int va, input int vf, input int vs,
                                          input int vb);
        int ht, vt, pos, h, v;
        logic [39:0] r;
        r = '0;
        if (kk == 0) return r;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        pos = kk % (ht * vt);
        h   = pos % ht;
        v   = pos / ht;
        r[39:29] = 11'(h);
        r[28:18] = 11'(v);
        r[17]    = (h >= ha + hf) && (h < ha + hf + hs);
        r[16]    = (v >= va + vf) && (v < va + vf + vs);
        r[15]    = (h >= ha);
        r[14]    = (v >= va);
        r[1]     = (pos == 0);
        r[0]     = (h == ht - 1);
        return r;
    endfunction

    function automatic logic [39:0] obs_def();
        return {u_if_def.hcount, u_if_def.vcount, u_if_def.hsync, u_if_def.vsync,
                u_if_def.hblnk, u_if_def.vblnk, u_if_def.rgb, sof_def, eol_def};
    endfunction

    function automatic logic [39:0] obs_sml();
        return {u_if_sml.hcount, u_if_sml.vcount, u_if_sml.hsync, u_if_sml.vsync,
                u_if_sml.hblnk, u_if_sml.vblnk, u_if_sml.rgb, sof_sml, eol_sml};
    endfunction

    task automatic check_all();
        logic [39:0] ed, es;
        ed = model(k, DH_A, DH_F, DH_S, DH_B, DV_A, DV_F, DV_S, DV_B);
        es = model(k, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B);
        check_val("def_state", obs_def(), ed);
        check_val("sml_state", obs_sml(), es);
`ifdef VGA_FRAME_CNT_EN
        check_val("def_frame_cnt", fc_def_o, fc_def);
        check_val("sml_frame_cnt", fc_sml_o, fc_sml);
`endif
        if (eol_sml) eol_cnt++;
        if (sof_sml) begin
            if (have_prev) begin
                check_val("frame_period", cyc - prev_cyc, S_FRAME);
                check_val("eol_per_frame", eol_cnt, SVT);
            end
            have_prev = 1;
            prev_cyc  = cyc;
            eol_cnt   = 0;
        end
    endtask

    task automatic tick();
        logic [39:0] ed, es;
        @(posedge clk);
        cyc++;
        if (rst) begin
            k++;
            ed = model(k, DH_A, DH_F, DH_S, DH_B, DV_A, DV_F, DV_S, DV_B);
            es = model(k, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B);
            if (ed[1]) fc_def = fc_def + 16'd1;
            if (es[1]) fc_sml = fc_sml + 16'd1;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called at a falling edge: drops reset between edges and checks it acts at once
    task automatic async_reset(input int hold);
        #2;
        rst       = 1'b0;
        k         = 0;
        fc_def    = '0;
        fc_sml    = '0;
        have_prev = 0;
        eol_cnt   = 0;
        #1;
        check_val("async_rst_def", obs_def(), 40'd0);
        check_val("async_rst_sml", obs_sml(), 40'd0);
        run(hold);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b0;
        run(5);
        rst = 1'b1;

        // Two full default lines: blank/sync edges and the first line wrap
        run(2 * DHT + 20);

        // Mid-line reset at hcount 500 on the default-size generator
        for (int i = 0; i < 2 * DHT && (k % DHT) != 500; i++) tick();
        check_val("hcount_at_500", u_if_def.hcount, 11'd500);
        async_reset(3);

        // Random run lengths interrupted by random asynchronous resets
        for (int t = 0; t < 8; t++) begin
            run($urandom_range(30, 1500));
            async_reset($urandom_range(1, 4));
        end

`ifdef VGA_FRAME_CNT_EN
        run(S_FRAME + 100);
        force u_sml.r_frame_cnt = 16'hFFFF;
        fc_sml = 16'hFFFF;
        #1;
        release u_sml.r_frame_cnt;
`endif

        // Uninterrupted frames so period and lines-per-frame are measured
        run(3 * S_FRAME + 50);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
